// File: rtl/pixcap_pkg.sv
//------------------------------------------------------------------------------
// Module   : pixcap_pkg
// Brief    : Shared types and constants for the pixel frame capture block.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pixcap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPOSE = 2'd1,
    READ   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam int FRAME_PIX = 4;
  localparam int ROWS      = 2;

  // Row-select patterns as {NRE_1, NRE_2}; selects are active low
  localparam logic [1:0] ROW0_SEL = 2'b01;
  localparam logic [1:0] ROW1_SEL = 2'b10;

endpackage

`default_nettype wire

// File: rtl/pixcap_out_reg.sv
//------------------------------------------------------------------------------
// Module   : pixcap_out_reg
// Brief    : Single-entry valid/ready output register carrying pixel and last.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pixcap_out_reg
  import pixcap_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [PIX_W-1:0] i_data,
  input  logic             i_last,
  output logic [PIX_W-1:0] o_data,
  output logic             o_valid,
  output logic             o_last,
  input  logic             i_ready
);

  logic             r_valid;
  logic [PIX_W-1:0] r_data;
  logic             r_last;

  // Accept a new pixel whenever the slot is empty or drains this cycle
  assign o_ready = !r_valid || i_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_valid && o_ready) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule

`default_nettype wire

// File: rtl/pixel_frame_capture.sv
//------------------------------------------------------------------------------
// Module   : pixel_frame_capture
// Brief    : Captures two ADC rows selected by NRE_1/NRE_2 and streams the 2x2
//            frame over valid/ready. Define FRAME_CNT_EN to add frame_cnt.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pixel_frame_capture
  import pixcap_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int N_COLS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               NRE_1,
  input  logic               NRE_2,
  input  logic               ADC,
  input  logic               expose,
  input  logic               erase,
  input  logic [2*PIX_W-1:0] col_data,
  output logic [PIX_W-1:0]   pix_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_last,
  output logic               frame_err,
  output logic               busy
`ifdef FRAME_CNT_EN
  ,
  output logic [15:0]        frame_cnt
`endif
);

  if (N_COLS != 2 || ROWS * N_COLS != FRAME_PIX) begin : g_ncols_check
    $error("pixel_frame_capture: N_COLS must be 2");
  end

  localparam logic [2:0] c_feed_end  = 3'(FRAME_PIX);
  localparam logic [2:0] c_feed_last = 3'(FRAME_PIX - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_adc_q;
  logic               w_adc_rise;
  logic               r_r0;
  logic               r_r1;
  logic [2*PIX_W-1:0] r_row0;
  logic [2*PIX_W-1:0] r_row1;
  logic [2:0]         r_feed_idx;
  logic               r_frame_err;
  logic [1:0]         w_sel;
  logic               w_both;
  logic               w_err;
  logic               w_store0;
  logic               w_store1;
  logic               w_clear;
  logic               w_feed_valid;
  logic               w_feed_ready;
  logic               w_feed_fire;
  logic [PIX_W-1:0]   w_feed_data;
  logic               w_feed_last;
  logic               w_last_xfer;

  assign w_adc_rise   = ADC & ~r_adc_q;
  assign w_sel        = {NRE_1, NRE_2};
  assign w_both       = r_r0 & r_r1;
  assign w_feed_valid = (r_state == DRAIN) && (r_feed_idx != c_feed_end);
  assign w_feed_fire  = w_feed_valid && w_feed_ready;
  assign w_feed_last  = (r_feed_idx == c_feed_last);
  assign w_last_xfer  = pix_valid && pix_ready && pix_last;

  always_comb begin
    w_feed_data = '0;
    case (r_feed_idx[1:0])
      2'd0:    w_feed_data = r_row0[PIX_W-1:0];
      2'd1:    w_feed_data = r_row0[2*PIX_W-1:PIX_W];
      2'd2:    w_feed_data = r_row1[PIX_W-1:0];
      default: w_feed_data = r_row1[2*PIX_W-1:PIX_W];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_store0    = 1'b0;
    w_store1    = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_adc_rise) w_err = 1'b1;
        if (expose) w_state_nxt = EXPOSE;
      end
      EXPOSE: begin
        if (erase) w_state_nxt = IDLE;
        else if (!expose) w_state_nxt = READ;
      end
      READ: begin
        // erase outranks a coincident strobe: abort without storing
        if (erase && !w_both) begin
          w_err       = 1'b1;
          w_clear     = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_both && !ADC) begin
          w_state_nxt = DRAIN;
        end else if (w_adc_rise) begin
          if (w_sel == ROW0_SEL && !r_r0) w_store0 = 1'b1;
          else if (w_sel == ROW1_SEL && !r_r1) w_store1 = 1'b1;
          else w_err = 1'b1;
        end
      end
      DRAIN: begin
        if (w_adc_rise) w_err = 1'b1;
        if (w_last_xfer) begin
          w_clear     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_adc_q     <= 1'b0;
      r_r0        <= 1'b0;
      r_r1        <= 1'b0;
      r_row0      <= '0;
      r_row1      <= '0;
      r_feed_idx  <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_adc_q     <= ADC;
      r_frame_err <= w_err;
      if (w_clear) begin
        r_r0 <= 1'b0;
        r_r1 <= 1'b0;
      end else begin
        if (w_store0) begin
          r_r0   <= 1'b1;
          r_row0 <= col_data;
        end
        if (w_store1) begin
          r_r1   <= 1'b1;
          r_row1 <= col_data;
        end
      end
      if (r_state != DRAIN) r_feed_idx <= '0;
      else if (w_feed_fire) r_feed_idx <= r_feed_idx + 3'd1;
    end
  end

  pixcap_out_reg #(
    .PIX_W (PIX_W)
  ) u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_feed_valid),
    .o_ready (w_feed_ready),
    .i_data  (w_feed_data),
    .i_last  (w_feed_last),
    .o_data  (pix_data),
    .o_valid (pix_valid),
    .o_last  (pix_last),
    .i_ready (pix_ready)
  );

  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

`ifdef FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_frame_cnt <= '0;
    else if (w_last_xfer) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pixel_frame_capture.sv
//------------------------------------------------------------------------------
// Module   : tb_pixel_frame_capture
// Brief    : Self-checking bench for pixel_frame_capture with a frame-level model.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pixel_frame_capture;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        NRE_1     = 1'b1;
  logic        NRE_2     = 1'b1;
  logic        ADC       = 1'b0;
  logic        expose    = 1'b0;
  logic        erase     = 1'b0;
  logic        pix_ready = 1'b1;
  logic [15:0] col_data  = 16'h0;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_last;
  logic        frame_err;
  logic        busy;
`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  pixel_frame_capture #(.PIX_W(8), .N_COLS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .NRE_1     (NRE_1),
    .NRE_2     (NRE_2),
    .ADC       (ADC),
    .expose    (expose),
    .erase     (erase),
    .col_data  (col_data),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_last  (pix_last),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
  } pix_t;

  localparam int P_IDLE  = 0;
  localparam int P_READ  = 1;
  localparam int P_DRAIN = 2;

  int   checks = 0;
  int   errors = 0;
  pix_t exp_q[$];
  pix_t got_log[$];
  int   exp_err = 0;
  int   seen_err = 0;
  int   exp_frames = 0;
  int   m_phase = P_IDLE;
  bit   m_r0, m_r1;
  logic [15:0] m_row0, m_row1;
  bit   rand_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Compare process: every accepted pixel against the model queue, plus stall stability
  bit         prev_stall = 1'b0;
  logic [7:0] prev_d;
  logic       prev_l;
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(pix_valid), 32'd1);
        chk("hold_data", 32'(pix_data), 32'(prev_d));
        chk("hold_last", 32'(pix_last), 32'(prev_l));
      end
      if (frame_err) seen_err++;
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel got=%0h exp=none", pix_data);
        end else begin
          pix_t p;
          p = exp_q.pop_front();
          chk("pix_data", 32'(pix_data), 32'(p.d));
          chk("pix_last", 32'(pix_last), 32'(p.l));
          got_log.push_back('{d: pix_data, l: pix_last});
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_d     = pix_data;
      prev_l     = pix_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) pix_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Frame-level model: a strobe either fills an empty row or is a violation
  task automatic model_strobe(input logic n1, input logic n2, input logic [15:0] d);
    if (m_phase != P_READ) exp_err++;
    else if (!n1 && n2 && !m_r0) begin m_r0 = 1'b1; m_row0 = d; end
    else if (n1 && !n2 && !m_r1) begin m_r1 = 1'b1; m_row1 = d; end
    else exp_err++;
    if (m_phase == P_READ && m_r0 && m_r1) begin
      exp_q.push_back('{d: m_row0[7:0],  l: 1'b0});
      exp_q.push_back('{d: m_row0[15:8], l: 1'b0});
      exp_q.push_back('{d: m_row1[7:0],  l: 1'b0});
      exp_q.push_back('{d: m_row1[15:8], l: 1'b1});
      m_r0 = 1'b0;
      m_r1 = 1'b0;
      m_phase = P_DRAIN;
      exp_frames++;
    end
  endtask

  task automatic strobe(input logic n1, input logic n2, input logic [15:0] d);
    NRE_1 = n1; NRE_2 = n2; col_data = d; ADC = 1'b1;
    tick();
    ADC = 1'b0; NRE_1 = 1'b1; NRE_2 = 1'b1; col_data = 16'($urandom);
    tick();
    model_strobe(n1, n2, d);
  endtask

  task automatic go_read(input int n);
    expose = 1'b1;
    repeat (n) tick();
    expose = 1'b0;
    tick();
    tick();
    m_phase = P_READ;
  endtask

  task automatic do_erase(input bit with_adc, input logic [15:0] d);
    erase = 1'b1;
    if (with_adc) begin NRE_1 = 1'b0; NRE_2 = 1'b1; col_data = d; ADC = 1'b1; end
    tick();
    erase = 1'b0; ADC = 1'b0; NRE_1 = 1'b1; NRE_2 = 1'b1;
    tick();
    exp_err++;
    m_r0 = 1'b0; m_r1 = 1'b0; m_phase = P_IDLE;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || pix_valid) && n < 300) begin tick(); n++; end
    chk({nm, "_idle_timeout"}, 32'(busy || pix_valid), 32'd0);
    m_phase = P_IDLE;
    repeat (2) tick();
    chk({nm, "_err_count"}, 32'(seen_err), 32'(exp_err));
    chk({nm, "_queue_left"}, 32'(exp_q.size()), 32'd0);
`ifdef FRAME_CNT_EN
    chk({nm, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames[15:0]));
`endif
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk({nm, "_pix_data"},  32'(pix_data),  32'd0);
    chk({nm, "_pix_last"},  32'(pix_last),  32'd0);
    chk({nm, "_frame_err"}, 32'(frame_err), 32'd0);
    chk({nm, "_busy"},      32'(busy),      32'd0);
`ifdef FRAME_CNT_EN
    chk({nm, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
`endif
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs(nm);
    exp_q.delete();
    m_r0 = 1'b0; m_r1 = 1'b0; m_phase = P_IDLE; exp_frames = 0;
    @(negedge clk);
    #2 reset = 1'b1;
    tick();
  endtask

  task automatic check_log_1122(input string nm);
    logic [7:0] want [4];
    want = '{8'h11, 8'h22, 8'h33, 8'h44};
    chk({nm, "_log_size"}, 32'(got_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_log.size(); i++) begin
      chk($sformatf("%s_lit_data%0d", nm, i), 32'(got_log[i].d), 32'(want[i]));
      chk($sformatf("%s_lit_last%0d", nm, i), 32'(got_log[i].l), (i == 3) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] t1_steps [10];
    logic       prev_adc;
    int         n;
    t1_steps = '{3'b110, 3'b110, 3'b010, 3'b011, 3'b010,
                 3'b110, 3'b100, 3'b101, 3'b100, 3'b110};

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_state");
    @(negedge clk);
    #2 reset = 1'b1;
    tick();

    // 1: literal readout sequence, ready tied high
    got_log.delete();
    go_read(5);
    prev_adc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      {NRE_1, NRE_2, ADC} = t1_steps[i];
      col_data = (t1_steps[i] == 3'b011) ? 16'h2211 :
                 (t1_steps[i] == 3'b101) ? 16'h4433 : 16'h0000;
      tick();
      if (ADC && !prev_adc) model_strobe(NRE_1, NRE_2, col_data);
      prev_adc = ADC;
    end
    {NRE_1, NRE_2, ADC} = 3'b110;
    wait_idle("t1");
    check_log_1122("t1");

    // 2: back-pressure on the second pixel
    got_log.delete();
    go_read(2);
    strobe(1'b0, 1'b1, 16'h2211);
    strobe(1'b1, 1'b0, 16'h4433);
    n = 0;
    while (!pix_valid && n < 20) begin tick(); n++; end
    chk("t2_first_pixel", 32'(pix_data), 32'h11);
    tick();
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_valid", 32'(pix_valid), 32'd1);
      chk("t2_stall_data", 32'(pix_data), 32'h22);
      tick();
    end
    pix_ready = 1'b1;
    wait_idle("t2");
    check_log_1122("t2");

    // 3: both selects low, then valid rows
    go_read(1);
    strobe(1'b0, 1'b0, 16'hDEAD);
    strobe(1'b0, 1'b1, 16'hA1B2);
    strobe(1'b1, 1'b0, 16'hC3D4);
    wait_idle("t3");

    // 4: erase after only the first row, then a clean frame
    go_read(3);
    strobe(1'b0, 1'b1, 16'h5566);
    do_erase(1'b0, 16'h0);
    wait_idle("t4_abort");
    go_read(1);
    strobe(1'b1, 1'b0, 16'h7788);
    strobe(1'b0, 1'b1, 16'h99AA);
    wait_idle("t4");

    // 5: overrun strobe while the drain is stalled, plus one in IDLE
    go_read(2);
    pix_ready = 1'b0;
    strobe(1'b0, 1'b1, 16'h0102);
    strobe(1'b1, 1'b0, 16'h0304);
    repeat (3) tick();
    strobe(1'b0, 1'b1, 16'hFFFF);
    pix_ready = 1'b1;
    wait_idle("t5");
    strobe(1'b1, 1'b0, 16'h1234);
    wait_idle("t5_idle_overrun");

    // erase and strobe in the same READ cycle
    go_read(1);
    strobe(1'b1, 1'b0, 16'hBEEF);
    do_erase(1'b1, 16'hCAFE);
    wait_idle("erase_adc");

    // 6: reset in READ and in DRAIN, then recovery
    go_read(2);
    strobe(1'b0, 1'b1, 16'h1111);
    do_reset("rst_read");
    go_read(2);
    pix_ready = 1'b0;
    strobe(1'b0, 1'b1, 16'h2222);
    strobe(1'b1, 1'b0, 16'h3333);
    repeat (2) tick();
    do_reset("rst_drain");
    pix_ready = 1'b1;
    go_read(1);
    strobe(1'b0, 1'b1, 16'h4545);
    strobe(1'b1, 1'b0, 16'h6767);
    wait_idle("post_reset");

    // randomized frames with random back-pressure and violations
    rand_ready = 1'b1;
    for (int f = 0; f < 25; f++) begin
      go_read($urandom_range(1, 4));
      n = 0;
      while (m_phase == P_READ && n < 8) begin
        int r;
        r = $urandom_range(0, 11);
        if (r == 0) do_erase(1'($urandom_range(0, 1)), 16'($urandom));
        else if (r == 1) strobe(1'b1, 1'b1, 16'($urandom));
        else if (r == 2) strobe(1'b0, 1'b0, 16'($urandom));
        else if (r < 7) strobe(1'b0, 1'b1, 16'($urandom));
        else strobe(1'b1, 1'b0, 16'($urandom));
        n++;
      end
      if (m_phase == P_READ) do_erase(1'b0, 16'h0);
      wait_idle("rand");
    end
    rand_ready = 1'b0;
    pix_ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
